// File: rtl/iq_tx_serializer.sv
// iq_tx_serializer
// Read-side consumer of the dual-clock complex IQ FIFO, in the FIFO read clock
// domain. Pops 32-bit {I,Q} words and builds the modem TX frame
//   I_SYNC(2)=10  I_DATA(13)  I_CTRL(1)=0  Q_SYNC(2)=01  Q_DATA(13)  Q_CTRL(1)=0
// then shifts it out MSB-first, SYM_BITS per clock. The next word is
// prefetched during the current word so consecutive words stream without gaps.
//
// Optional feature macro: TX_DEBUG_PATTERN_EN (adds debug_pattern_i and a
// 13-bit ramp generator that replaces the FIFO samples while it is high).
//
// Ports:
//   clk_i           clock (same as FIFO rd_clk_i)
//   rst_i           synchronous active-high reset
//   enable_i        allow fetching new words
//   fifo_rd_en_o    registered pop strobe to the FIFO
//   fifo_rd_data_i  FIFO data [31:16]=I [15:0]=Q, valid the cycle after the pop
//   fifo_empty_i    FIFO empty flag
//   tx_bits_o       serialized frame bits, MSB first
//   tx_valid_o      tx_bits_o carries frame data
//   tx_frame_o      first beat of each word
//   underrun_o      sticky underrun flag
//   underrun_clr_i  clears underrun_o (a simultaneous set wins)
//   words_sent_o    count of completed words (wraps)
//   debug_pattern_i (TX_DEBUG_PATTERN_EN only) select ramp test pattern
module iq_tx_serializer #(
  parameter int SYM_BITS  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  output logic                 fifo_rd_en_o,
  input  logic [31:0]          fifo_rd_data_i,
  input  logic                 fifo_empty_i,
  output logic [SYM_BITS-1:0]  tx_bits_o,
  output logic                 tx_valid_o,
  output logic                 tx_frame_o,
  output logic                 underrun_o,
  input  logic                 underrun_clr_i,
`ifdef TX_DEBUG_PATTERN_EN
  output logic [CNT_WIDTH-1:0] words_sent_o,
  input  logic                 debug_pattern_i
`else
  output logic [CNT_WIDTH-1:0] words_sent_o
`endif
);

  localparam int BEATS  = 32 / SYM_BITS;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  // The pop strobe is registered, so the prefetch decision is taken one beat
  // before the strobe must be visible (strobe on beat N-2, data on beat N-1).
  localparam logic [BEAT_W-1:0] PREF_BEAT = BEAT_W'(BEATS - 3);

  // REQ: pop strobe visible to the FIFO; FETCH: popped data on fifo_rd_data_i.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FETCH = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  function automatic logic [31:0] build_frame(input logic [31:0] d);
    build_frame = {2'b10, d[28:16], 1'b0, 2'b01, d[12:0], 1'b0};
  endfunction

  state_t                state_r, state_s;
  logic [BEAT_W-1:0]     beat_r, beat_s;
  logic [31:0]           shift_r, shift_s;
  logic                  pend_r, pend_s;
  logic                  starve_r, starve_s;
  logic                  rd_en_r, rd_en_s;
  logic [SYM_BITS-1:0]   tx_bits_r, tx_bits_s;
  logic                  tx_valid_r, tx_valid_s;
  logic                  tx_frame_r, tx_frame_s;
  logic                  underrun_r, underrun_s;
  logic [CNT_WIDTH-1:0]  words_r, words_s;
  logic                  load_s;
  logic [31:0]           src_s;
  logic [31:0]           frame_s;

`ifdef TX_DEBUG_PATTERN_EN
  logic [12:0] ramp_r;

  assign src_s = debug_pattern_i ? {3'b000, ramp_r, 3'b000, ~ramp_r} : fifo_rd_data_i;

  // Ramp pattern generator, advancing once per loaded word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ramp_r <= 13'd0;
    end else if (load_s) begin
      ramp_r <= ramp_r + 13'd1;
    end else begin
      ramp_r <= ramp_r;
    end
  end
`else
  assign src_s = fifo_rd_data_i;
`endif

  assign frame_s = build_frame(src_s);

  // Next-state, datapath and output decode.
  always_comb begin
    state_s    = state_r;
    beat_s     = beat_r;
    shift_s    = shift_r;
    pend_s     = pend_r;
    starve_s   = starve_r;
    rd_en_s    = 1'b0;
    tx_bits_s  = {SYM_BITS{1'b0}};
    tx_valid_s = 1'b0;
    tx_frame_s = 1'b0;
    underrun_s = underrun_r & ~underrun_clr_i;
    words_s    = words_r;
    load_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          rd_en_s = 1'b1;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        load_s = 1'b1;
        state_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (beat_r == LAST_BEAT) begin
          words_s  = words_r + CNT_WIDTH'(1);
          starve_s = 1'b0;
          if (pend_r) begin
            load_s = 1'b1;
            pend_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
            beat_s  = {BEAT_W{1'b0}};
            if (starve_r) begin
              underrun_s = 1'b1;
            end else begin
              underrun_s = underrun_r & ~underrun_clr_i;
            end
          end
        end else begin
          tx_bits_s  = shift_r[31 -: SYM_BITS];
          shift_s    = shift_r << SYM_BITS;
          beat_s     = beat_r + BEAT_W'(1);
          tx_valid_s = 1'b1;
          if (beat_r == PREF_BEAT) begin
            if (enable_i && !fifo_empty_i) begin
              rd_en_s  = 1'b1;
              pend_s   = 1'b1;
              starve_s = 1'b0;
            end else begin
              // Only an enabled stream that finds the FIFO dry is an underrun.
              starve_s = enable_i & fifo_empty_i;
            end
          end else begin
            starve_s = starve_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Loading a word presents its first beat directly so beat 0 appears the
    // cycle after the data is on the FIFO port.
    if (load_s) begin
      tx_bits_s  = frame_s[31 -: SYM_BITS];
      shift_s    = frame_s << SYM_BITS;
      beat_s     = {BEAT_W{1'b0}};
      tx_valid_s = 1'b1;
      tx_frame_s = 1'b1;
    end else begin
      tx_frame_s = 1'b0;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      beat_r     <= {BEAT_W{1'b0}};
      shift_r    <= 32'd0;
      pend_r     <= 1'b0;
      starve_r   <= 1'b0;
      rd_en_r    <= 1'b0;
      tx_bits_r  <= {SYM_BITS{1'b0}};
      tx_valid_r <= 1'b0;
      tx_frame_r <= 1'b0;
      underrun_r <= 1'b0;
      words_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      beat_r     <= beat_s;
      shift_r    <= shift_s;
      pend_r     <= pend_s;
      starve_r   <= starve_s;
      rd_en_r    <= rd_en_s;
      tx_bits_r  <= tx_bits_s;
      tx_valid_r <= tx_valid_s;
      tx_frame_r <= tx_frame_s;
      underrun_r <= underrun_s;
      words_r    <= words_s;
    end
  end

  assign fifo_rd_en_o = rd_en_r;
  assign tx_bits_o    = tx_bits_r;
  assign tx_valid_o   = tx_valid_r;
  assign tx_frame_o   = tx_frame_r;
  assign underrun_o   = underrun_r;
  assign words_sent_o = words_r;

endmodule
